// File: rtl/boom_probe_unit_pkg.sv
// Shared encodings for the L1 probe unit: client coherence states, probe caps,
// ProbeAck report codes, FSM states and the probe coherence resolver.
package boom_probe_unit_pkg;

   localparam logic [1:0] COH_NOTHING = 2'd0;
   localparam logic [1:0] COH_BRANCH  = 2'd1;
   localparam logic [1:0] COH_TRUNK   = 2'd2;
   localparam logic [1:0] COH_DIRTY   = 2'd3;

   localparam logic [1:0] CAP_TO_T = 2'd0;
   localparam logic [1:0] CAP_TO_B = 2'd1;
   localparam logic [1:0] CAP_TO_N = 2'd2;

   localparam logic [2:0] REP_TTOB = 3'd0;
   localparam logic [2:0] REP_TTON = 3'd1;
   localparam logic [2:0] REP_BTON = 3'd2;
   localparam logic [2:0] REP_TTOT = 3'd3;
   localparam logic [2:0] REP_BTOB = 3'd4;
   localparam logic [2:0] REP_NTON = 3'd5;

   localparam logic [2:0] S_INVALID        = 3'd0;
   localparam logic [2:0] S_META_READ      = 3'd1;
   localparam logic [2:0] S_META_RESP      = 3'd2;
   localparam logic [2:0] S_MSHR_REQ       = 3'd3;
   localparam logic [2:0] S_RELEASE        = 3'd4;
   localparam logic [2:0] S_WRITEBACK_REQ  = 3'd5;
   localparam logic [2:0] S_WRITEBACK_RESP = 3'd6;
   localparam logic [2:0] S_META_WRITE     = 3'd7;

   typedef struct packed {
      logic [2:0] report;
      logic [1:0] new_coh;
      logic       dirty;
   } probe_res_t;

   // Unknown cap encodings fall into the toN branch.
   function automatic probe_res_t probe_resolve(input logic [1:0] param, input logic [1:0] coh);
      probe_res_t res;
      res.dirty = (coh == COH_DIRTY);
      case (param)
         CAP_TO_T: begin
            case (coh)
               COH_DIRTY, COH_TRUNK: begin res.report = REP_TTOT; res.new_coh = coh;         end
               COH_BRANCH:           begin res.report = REP_BTOB; res.new_coh = COH_BRANCH;  end
               default:              begin res.report = REP_NTON; res.new_coh = COH_NOTHING; end
            endcase
         end
         CAP_TO_B: begin
            case (coh)
               COH_DIRTY, COH_TRUNK: begin res.report = REP_TTOB; res.new_coh = COH_BRANCH;  end
               COH_BRANCH:           begin res.report = REP_BTOB; res.new_coh = COH_BRANCH;  end
               default:              begin res.report = REP_NTON; res.new_coh = COH_NOTHING; end
            endcase
         end
         default: begin
            case (coh)
               COH_DIRTY, COH_TRUNK: begin res.report = REP_TTON; res.new_coh = COH_NOTHING; end
               COH_BRANCH:           begin res.report = REP_BTON; res.new_coh = COH_NOTHING; end
               default:              begin res.report = REP_NTON; res.new_coh = COH_NOTHING; end
            endcase
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/boom_probe_unit_if.sv
// Probe-unit bus bundle: probe request, metadata read/write, ProbeAck,
// writeback request/response and busy-index ports.
interface boom_probe_unit_if #(
   parameter int nWays        = 4,
   parameter int idxBits      = 6,
   parameter int tagBits      = 20,
   parameter int blockOffBits = 6
);
   localparam int paddrBits = tagBits + idxBits + blockOffBits;

   logic                 req_valid;
   logic                 req_ready;
   logic [paddrBits-1:0] req_addr;
   logic [1:0]           req_param;

   logic                 meta_read_valid;
   logic                 meta_read_ready;
   logic [idxBits-1:0]   meta_read_idx;
   logic [tagBits-1:0]   meta_read_tag;
   logic [nWays-1:0]     meta_resp_way_en;
   logic [1:0]           meta_resp_coh;

   logic                 mshr_rdy;

   logic                 rep_valid;
   logic                 rep_ready;
   logic [paddrBits-1:0] rep_addr;
   logic [2:0]           rep_param;

   logic                 wb_req_valid;
   logic                 wb_req_ready;
   logic [tagBits-1:0]   wb_req_tag;
   logic [idxBits-1:0]   wb_req_idx;
   logic [nWays-1:0]     wb_req_way_en;
   logic [2:0]           wb_req_param;
   logic                 wb_req_voluntary;
   logic                 wb_resp;

   logic                 meta_write_valid;
   logic                 meta_write_ready;
   logic [idxBits-1:0]   meta_write_idx;
   logic [nWays-1:0]     meta_write_way_en;
   logic [tagBits-1:0]   meta_write_tag;
   logic [1:0]           meta_write_coh;

   logic                 idx_valid;
   logic [idxBits-1:0]   idx;

   modport slave (
      input  req_valid, req_addr, req_param,
      output req_ready,
      output meta_read_valid, meta_read_idx, meta_read_tag,
      input  meta_read_ready, meta_resp_way_en, meta_resp_coh, mshr_rdy,
      output rep_valid, rep_addr, rep_param,
      input  rep_ready,
      output wb_req_valid, wb_req_tag, wb_req_idx, wb_req_way_en, wb_req_param, wb_req_voluntary,
      input  wb_req_ready, wb_resp,
      output meta_write_valid, meta_write_idx, meta_write_way_en, meta_write_tag, meta_write_coh,
      input  meta_write_ready,
      output idx_valid, idx
   );

   modport master (
      output req_valid, req_addr, req_param,
      input  req_ready,
      input  meta_read_valid, meta_read_idx, meta_read_tag,
      output meta_read_ready, meta_resp_way_en, meta_resp_coh, mshr_rdy,
      input  rep_valid, rep_addr, rep_param,
      output rep_ready,
      input  wb_req_valid, wb_req_tag, wb_req_idx, wb_req_way_en, wb_req_param, wb_req_voluntary,
      output wb_req_ready, wb_resp,
      input  meta_write_valid, meta_write_idx, meta_write_way_en, meta_write_tag, meta_write_coh,
      output meta_write_ready,
      input  idx_valid, idx
   );

endinterface

// File: rtl/boom_probe_unit.sv
// TileLink-B probe handler for the non-blocking L1 D$: reads metadata, resolves
// the downgrade, acks clean probes and hands dirty hits to the writeback unit.
module boom_probe_unit
   import boom_probe_unit_pkg::*;
#(
   parameter int nWays        = 4,
   parameter int idxBits      = 6,
   parameter int tagBits      = 20,
   parameter int blockOffBits = 6
) (
   input  logic             clock_i,
   input  logic             reset_i,
   boom_probe_unit_if.slave bus
);
   localparam int paddrBits = tagBits + idxBits + blockOffBits;

   logic [2:0]         state_q,  state_d;
   logic [tagBits-1:0] tag_q,    tag_d;
   logic [idxBits-1:0] idx_q,    idx_d;
   logic [1:0]         param_q,  param_d;
   logic [nWays-1:0]   way_en_q, way_en_d;
   logic [1:0]         coh_q,    coh_d;

   logic               hit;
   probe_res_t         res;

   // A miss resolves as if the block were held in Nothing.
   assign hit = (way_en_q != {nWays{1'b0}});
   assign res = probe_resolve(param_q, hit ? coh_q : COH_NOTHING);

   // Next-state and field-latch logic for the probe FSM.
   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      idx_d    = idx_q;
      param_d  = param_q;
      way_en_d = way_en_q;
      coh_d    = coh_q;
      case (state_q)
         S_INVALID: begin
            if (bus.req_valid) begin
               state_d = S_META_READ;
               tag_d   = bus.req_addr[paddrBits-1 -: tagBits];
               idx_d   = bus.req_addr[blockOffBits +: idxBits];
               param_d = bus.req_param;
            end else begin
               state_d = S_INVALID;
            end
         end
         S_META_READ: begin
            if (bus.meta_read_ready) begin
               state_d = S_META_RESP;
            end else begin
               state_d = S_META_READ;
            end
         end
         S_META_RESP: begin
            way_en_d = bus.meta_resp_way_en;
            coh_d    = bus.meta_resp_coh;
            state_d  = S_MSHR_REQ;
         end
         S_MSHR_REQ: begin
            if (!bus.mshr_rdy) begin
               state_d = S_META_READ;
            end else if (hit && res.dirty) begin
               state_d = S_WRITEBACK_REQ;
            end else begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (bus.rep_ready) begin
               state_d = hit ? S_META_WRITE : S_INVALID;
            end else begin
               state_d = S_RELEASE;
            end
         end
         S_WRITEBACK_REQ: begin
            if (bus.wb_req_ready) begin
               state_d = S_WRITEBACK_RESP;
            end else begin
               state_d = S_WRITEBACK_REQ;
            end
         end
         S_WRITEBACK_RESP: begin
            if (bus.wb_resp) begin
               state_d = S_META_WRITE;
            end else begin
               state_d = S_WRITEBACK_RESP;
            end
         end
         S_META_WRITE: begin
            if (bus.meta_write_ready) begin
               state_d = S_INVALID;
            end else begin
               state_d = S_META_WRITE;
            end
         end
         default: begin
            state_d = S_INVALID;
         end
      endcase
   end

   // State and latched probe fields.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_INVALID;
         tag_q    <= {tagBits{1'b0}};
         idx_q    <= {idxBits{1'b0}};
         param_q  <= 2'd0;
         way_en_q <= {nWays{1'b0}};
         coh_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         idx_q    <= idx_d;
         param_q  <= param_d;
         way_en_q <= way_en_d;
         coh_q    <= coh_d;
      end
   end

   assign bus.req_ready         = (state_q == S_INVALID);
   assign bus.meta_read_valid   = (state_q == S_META_READ);
   assign bus.meta_read_idx     = idx_q;
   assign bus.meta_read_tag     = tag_q;

   assign bus.rep_valid         = (state_q == S_RELEASE);
   assign bus.rep_addr          = {tag_q, idx_q, {blockOffBits{1'b0}}};
   assign bus.rep_param         = res.report;

   assign bus.wb_req_valid      = (state_q == S_WRITEBACK_REQ);
   assign bus.wb_req_tag        = tag_q;
   assign bus.wb_req_idx        = idx_q;
   assign bus.wb_req_way_en     = way_en_q;
   assign bus.wb_req_param      = res.report;
   assign bus.wb_req_voluntary  = 1'b0;

   assign bus.meta_write_valid  = (state_q == S_META_WRITE);
   assign bus.meta_write_idx    = idx_q;
   assign bus.meta_write_way_en = way_en_q;
   assign bus.meta_write_tag    = tag_q;
   assign bus.meta_write_coh    = res.new_coh;

   assign bus.idx_valid         = (state_q != S_INVALID);
   assign bus.idx               = idx_q;

endmodule

// File: tb/tb_boom_probe_unit.sv
// Directed and randomized probe scenarios for boom_probe_unit, checked against a
// permission-level model of the probe downgrade rules.
module tb_boom_probe_unit;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   cyc_q  = 0;
   int   rep_tbl [3][3];

   always #5 clk = ~clk;

   always @(posedge clk) cyc_q <= cyc_q + 1;

   boom_probe_unit_if #(.nWays(4), .idxBits(6), .tagBits(20), .blockOffBits(6)) bus ();

   boom_probe_unit #(.nWays(4), .idxBits(6), .tagBits(20), .blockOffBits(6)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Permission levels N=0,B=1,T=2; the result is min(held, cap) and the report
   // names the from->to pair. Returns {report, new_coh}.
   function automatic logic [4:0] model(input logic [1:0] cap, input bit hit, input logic [1:0] coh);
      int c, from, capl, to;
      logic [2:0] rep;
      logic [1:0] ncoh;
      c    = hit ? int'(coh) : 0;
      from = (c >= 2) ? 2 : c;
      capl = (cap == 2'd0) ? 2 : (cap == 2'd1) ? 1 : 0;
      to   = (from < capl) ? from : capl;
      rep  = 3'(rep_tbl[from][to]);
      ncoh = (to == 2) ? 2'(c) : 2'(to);
      return {rep, ncoh};
   endfunction

   task automatic do_probe(input logic [31:0] addr, input logic [1:0] cap, input logic [3:0] way,
                           input logic [1:0] coh, input int nblock, input int stall,
                           input int wbd, input bit abort_wb);
      logic [19:0] tag;
      logic [5:0]  ix;
      logic [4:0]  m;
      bit          dirty;
      int          t0;
      tag   = addr[31:12];
      ix    = addr[11:6];
      m     = model(cap, way != 4'd0, coh);
      dirty = (way != 4'd0) && (coh == 2'd3);

      @(negedge clk);
      chk("idle_req_ready", bus.req_ready, 1);
      chk("idle_idx_valid", bus.idx_valid, 0);
      bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_param = cap;
      @(posedge clk); @(negedge clk);
      t0 = cyc_q;
      bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_param = 2'($urandom);

      for (int p = 0; p <= nblock; p++) begin
         chk("meta_read_valid", bus.meta_read_valid, 1);
         chk("meta_read_idx", bus.meta_read_idx, ix);
         chk("meta_read_tag", bus.meta_read_tag, tag);
         chk("busy_req_ready", bus.req_ready, 0);
         chk("busy_idx", {bus.idx_valid, bus.idx}, {1'b1, ix});
         bus.meta_read_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         bus.meta_read_ready = 1'b0;
         chk("meta_read_drop", bus.meta_read_valid, 0);
         if (p < nblock) begin
            bus.meta_resp_way_en = 4'($urandom); bus.meta_resp_coh = 2'($urandom);
         end else begin
            bus.meta_resp_way_en = way; bus.meta_resp_coh = coh;
         end
         @(posedge clk); @(negedge clk);
         bus.meta_resp_way_en = 4'($urandom); bus.meta_resp_coh = 2'($urandom);
         bus.mshr_rdy = (p < nblock) ? 1'b0 : 1'b1;
         @(posedge clk); @(negedge clk);
         bus.mshr_rdy = 1'($urandom);
      end

      if (!dirty) begin
         for (int s = 0; s <= stall; s++) begin
            chk("rep_valid", bus.rep_valid, 1);
            chk("rep_addr", bus.rep_addr, {tag, ix, 6'd0});
            chk("rep_param", bus.rep_param, m[4:2]);
            chk("rep_no_wb", {bus.wb_req_valid, bus.meta_write_valid, bus.req_ready}, 3'b000);
            bus.rep_ready = (s == stall);
            bus.wb_resp   = (s < stall) ? 1'($urandom) : 1'b0;
            @(posedge clk); @(negedge clk);
            bus.rep_ready = 1'b0; bus.wb_resp = 1'b0;
         end
         if (nblock == 0 && stall == 0) chk("rep_latency", 64'(cyc_q - t0), 4);
      end else begin
         chk("wb_req_valid", bus.wb_req_valid, 1);
         chk("wb_req_tag", bus.wb_req_tag, tag);
         chk("wb_req_idx", bus.wb_req_idx, ix);
         chk("wb_req_way_en", bus.wb_req_way_en, way);
         chk("wb_req_param", bus.wb_req_param, m[4:2]);
         chk("wb_voluntary", bus.wb_req_voluntary, 0);
         chk("wb_no_rep", bus.rep_valid, 0);
         bus.wb_req_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         bus.wb_req_ready = 1'b0;
         if (abort_wb) begin
            chk("wb_resp_wait", {bus.wb_req_valid, bus.idx_valid}, 2'b01);
            rst = 1'b1;
            #1;
            chk("abort_req_ready", bus.req_ready, 1);
            chk("abort_valids", {bus.meta_read_valid, bus.rep_valid, bus.wb_req_valid,
                                 bus.meta_write_valid, bus.idx_valid}, 5'b00000);
            @(posedge clk); @(negedge clk);
            rst = 1'b0; bus.wb_resp = 1'b1;
            @(posedge clk); @(negedge clk);
            bus.wb_resp = 1'b0;
            chk("abort_ignore_wb_resp", {bus.req_ready, bus.meta_write_valid, bus.idx_valid}, 3'b100);
            chk("abort_fields_cleared", bus.meta_read_idx, 0);
            return;
         end
         for (int d = 0; d < wbd; d++) begin
            chk("wb_wait", {bus.wb_req_valid, bus.meta_write_valid, bus.rep_valid, bus.idx_valid}, 4'b0001);
            @(posedge clk); @(negedge clk);
         end
         bus.wb_resp = 1'b1;
         @(posedge clk); @(negedge clk);
         bus.wb_resp = 1'b0;
      end

      if (way != 4'd0) begin
         chk("meta_write_valid", bus.meta_write_valid, 1);
         chk("meta_write_idx", bus.meta_write_idx, ix);
         chk("meta_write_tag", bus.meta_write_tag, tag);
         chk("meta_write_way_en", bus.meta_write_way_en, way);
         chk("meta_write_coh", bus.meta_write_coh, m[1:0]);
         bus.meta_write_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         bus.meta_write_ready = 1'b0;
         if (!dirty && nblock == 0 && stall == 0) chk("hit_latency", 64'(cyc_q - t0), 5);
      end
      chk("done_req_ready", bus.req_ready, 1);
      chk("done_valids", {bus.rep_valid, bus.wb_req_valid, bus.meta_write_valid, bus.idx_valid}, 4'b0000);
   endtask

   initial begin
      logic [3:0] one;
      logic [3:0] w;
      bit         hit;
      one     = 4'b0001;
      rep_tbl = '{'{5, 7, 7}, '{2, 4, 7}, '{1, 0, 3}};
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_addr = 32'd0; bus.req_param = 2'd0;
      bus.meta_read_ready = 1'b0; bus.meta_resp_way_en = 4'd0; bus.meta_resp_coh = 2'd0;
      bus.mshr_rdy = 1'b1; bus.rep_ready = 1'b0; bus.wb_req_ready = 1'b0; bus.wb_resp = 1'b0;
      bus.meta_write_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_req_ready", bus.req_ready, 1);
      chk("reset_valids", {bus.meta_read_valid, bus.rep_valid, bus.wb_req_valid,
                           bus.meta_write_valid, bus.idx_valid}, 5'b00000);
      chk("reset_fields", {bus.rep_addr, bus.idx}, 0);
      rst = 1'b0;

      do_probe(32'h8000_1040, 2'd2, 4'b0000, 2'd3, 0, 0, 0, 1'b0);  // miss, toN
      do_probe(32'h1234_5680, 2'd1, 4'b0010, 2'd2, 0, 0, 0, 1'b0);  // clean Trunk hit, toB
      do_probe(32'hABCD_E7C0, 2'd2, 4'b0100, 2'd3, 0, 0, 10, 1'b0); // dirty hit, toN
      do_probe(32'h0F0F_0300, 2'd0, 4'b1000, 2'd1, 3, 0, 0, 1'b0);  // MSHR conflict, 3 retries
      do_probe(32'h5555_5540, 2'd1, 4'b0001, 2'd2, 0, 5, 0, 1'b0);  // ack backpressure
      do_probe(32'h3C3C_3C00, 2'd3, 4'b0010, 2'd1, 0, 0, 0, 1'b0);  // cap 3 acts as toN
      do_probe(32'h7777_0040, 2'd0, 4'b0001, 2'd3, 0, 0, 2, 1'b0);  // dirty hit, toT
      do_probe(32'h9999_9FC0, 2'd2, 4'b0100, 2'd3, 0, 0, 4, 1'b1);  // reset mid-writeback

      for (int i = 0; i < 40; i++) begin
         hit = 1'($urandom);
         w   = hit ? (one << $urandom_range(3, 0)) : 4'd0;
         do_probe($urandom, 2'($urandom), w, 2'($urandom), $urandom_range(2, 0),
                  $urandom_range(3, 0), $urandom_range(4, 0), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
